// File: rtl/video_timing_gen.sv
// Programmable raster timing generator: double-buffered timing registers, raster counters, sync/blank/window, strobes.
// Optional frame interrupt is built only when VIDEO_TIMING_INT_EN is defined; otherwise int_n is tied high.
module video_timing_gen #(
    parameter int SUB_W        = 2,
    parameter int HC_W         = 9,
    parameter int VC_W         = 9,
    parameter int CFG_W        = 9,
    parameter int BLINK_W      = 5,
    parameter int H_AREA       = 256,
    parameter int V_AREA       = 192,
    parameter int SCREEN_DELAY = 13,
    parameter int INT_LEN      = 32,
    parameter int DEF_H_TOTAL  = 448,
    parameter int DEF_HBLANK_S = 322,
    parameter int DEF_HSYNC_S  = 334,
    parameter int DEF_HSYNC_E  = 367,
    parameter int DEF_HBLANK_E = 407,
    parameter int DEF_V_TOTAL  = 320,
    parameter int DEF_VSYNC_S  = 248,
    parameter int DEF_VSYNC_E  = 256
) (
    input  logic             clk28,
    input  logic             rst_n,
    input  logic             cfg_we,
    input  logic [2:0]       cfg_addr,
    input  logic [CFG_W-1:0] cfg_wdata,
    output logic [CFG_W-1:0] cfg_rdata,
    output logic [SUB_W:0]   ck,
    output logic [HC_W-1:0]  hc,
    output logic [VC_W-1:0]  vc,
    output logic             hsync_n,
    output logic             vsync_n,
    output logic             csync_n,
    output logic             blank,
    output logic             screen_show,
    output logic             line_start,
    output logic             frame_start,
    output logic             even_line,
    output logic             blink,
    output logic             int_n
);

    localparam int HC0_W = HC_W + SUB_W;
    localparam int CMP_W = CFG_W + 1;
    localparam int SCR_S = SCREEN_DELAY * (2 ** SUB_W) - 1;
    localparam int SCR_E = (H_AREA + SCREEN_DELAY) * (2 ** SUB_W) - 1;

    localparam int R_H_TOTAL  = 0;
    localparam int R_HBLANK_S = 1;
    localparam int R_HSYNC_S  = 2;
    localparam int R_HSYNC_E  = 3;
    localparam int R_HBLANK_E = 4;
    localparam int R_V_TOTAL  = 5;
    localparam int R_VSYNC_S  = 6;
    localparam int R_VSYNC_E  = 7;

    function automatic logic [CFG_W-1:0] def_value(input int idx);
        case (idx)
            R_H_TOTAL:  return CFG_W'(DEF_H_TOTAL);
            R_HBLANK_S: return CFG_W'(DEF_HBLANK_S);
            R_HSYNC_S:  return CFG_W'(DEF_HSYNC_S);
            R_HSYNC_E:  return CFG_W'(DEF_HSYNC_E);
            R_HBLANK_E: return CFG_W'(DEF_HBLANK_E);
            R_V_TOTAL:  return CFG_W'(DEF_V_TOTAL);
            R_VSYNC_S:  return CFG_W'(DEF_VSYNC_S);
            default:    return CFG_W'(DEF_VSYNC_E);
        endcase
    endfunction

    // Half-open [s, e) test; s >= e yields an empty region.
    function automatic logic in_range(input logic [CMP_W-1:0] v,
                                      input logic [CFG_W-1:0] s,
                                      input logic [CFG_W-1:0] e);
        return (v >= CMP_W'(s)) && (v < CMP_W'(e));
    endfunction

    logic [CFG_W-1:0]   shadow_val [8];
    logic [CFG_W-1:0]   active_val [8];

    logic [HC0_W-1:0]   hc0_reg;
    logic [VC_W-1:0]    vc_reg;
    logic [CMP_W-1:0]   hc_ext;
    logic [CMP_W-1:0]   vc_ext;
    logic               line_wrap;
    logic               frame_wrap;
    logic               hs_act;
    logic               vs_act;
    logic               hb_act;
    logic               scr_act;

    logic               hsync_n_reg;
    logic               vsync_n_reg;
    logic               csync_n_reg;
    logic               blank_reg;
    logic               screen_reg;
    logic               line_start_reg;
    logic               frame_start_reg;
    logic               even_reg;
    logic [BLINK_W-1:0] blink_cnt_reg;

    // Shadow takes CPU writes; active is reloaded from shadow only at frame wrap.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_cfg
            logic [CFG_W-1:0] shadow_reg;
            logic [CFG_W-1:0] active_reg;

            always_ff @(posedge clk28 or negedge rst_n) begin
                if (!rst_n) begin
                    shadow_reg <= def_value(gi);
                    active_reg <= def_value(gi);
                end else begin
                    if (cfg_we && (cfg_addr == 3'(gi)))
                        shadow_reg <= cfg_wdata;
                    if (frame_wrap)
                        active_reg <= shadow_reg;
                end
            end

            assign shadow_val[gi] = shadow_reg;
            assign active_val[gi] = active_reg;
        end

        for (gi = 0; gi <= SUB_W; gi++) begin : g_ck
            assign ck[gi] = &hc0_reg[gi:0];
        end
    endgenerate

    assign cfg_rdata = shadow_val[cfg_addr];

    assign hc     = hc0_reg[HC0_W-1:SUB_W];
    assign vc     = vc_reg;
    assign hc_ext = CMP_W'(hc);
    assign vc_ext = CMP_W'(vc_reg);

    // Comparing hc+1 >= total (not equality) forces a wrap if the total shrinks below the count.
    assign line_wrap  = (&hc0_reg[SUB_W-1:0]) &&
                        ((hc_ext + CMP_W'(1)) >= CMP_W'(active_val[R_H_TOTAL]));
    assign frame_wrap = line_wrap &&
                        ((vc_ext + CMP_W'(1)) >= CMP_W'(active_val[R_V_TOTAL]));

    assign hs_act  = in_range(hc_ext, active_val[R_HSYNC_S],  active_val[R_HSYNC_E]);
    assign vs_act  = in_range(vc_ext, active_val[R_VSYNC_S],  active_val[R_VSYNC_E]);
    assign hb_act  = in_range(hc_ext, active_val[R_HBLANK_S], active_val[R_HBLANK_E]);
    assign scr_act = (int'(vc_reg) < V_AREA) &&
                     (int'(hc0_reg) >= SCR_S) && (int'(hc0_reg) < SCR_E);

    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            hc0_reg <= '0;
            vc_reg  <= '0;
        end else if (line_wrap) begin
            hc0_reg <= '0;
            vc_reg  <= frame_wrap ? '0 : vc_reg + VC_W'(1);
        end else begin
            hc0_reg <= hc0_reg + HC0_W'(1);
        end
    end

    // Strobes are registered on the wrap edge so they coincide with hc0 == 0.
    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            hsync_n_reg     <= 1'b1;
            vsync_n_reg     <= 1'b1;
            csync_n_reg     <= 1'b1;
            blank_reg       <= 1'b0;
            screen_reg      <= 1'b0;
            line_start_reg  <= 1'b0;
            frame_start_reg <= 1'b0;
            even_reg        <= 1'b0;
            blink_cnt_reg   <= '0;
        end else begin
            hsync_n_reg     <= ~hs_act;
            vsync_n_reg     <= ~vs_act;
            csync_n_reg     <= ~(hs_act ^ vs_act);
            blank_reg       <= vs_act | hb_act;
            screen_reg      <= scr_act;
            line_start_reg  <= line_wrap;
            frame_start_reg <= frame_wrap;
            if (line_wrap)
                even_reg <= ~even_reg;
            if (frame_wrap)
                blink_cnt_reg <= blink_cnt_reg + BLINK_W'(1);
        end
    end

    assign hsync_n     = hsync_n_reg;
    assign vsync_n     = vsync_n_reg;
    assign csync_n     = csync_n_reg;
    assign blank       = blank_reg;
    assign screen_show = screen_reg;
    assign line_start  = line_start_reg;
    assign frame_start = frame_start_reg;
    assign even_line   = even_reg;
    assign blink       = blink_cnt_reg[BLINK_W-1];

`ifdef VIDEO_TIMING_INT_EN
    localparam int INT_CLKS = INT_LEN * (2 ** SUB_W);
    localparam int INT_CW   = $clog2(INT_CLKS + 1);

    logic [INT_CW-1:0] int_cnt_reg;
    logic              int_n_reg;

    // Reload on every frame wrap, so a new frame_start while low restarts the pulse.
    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            int_n_reg   <= 1'b1;
            int_cnt_reg <= '0;
        end else if (frame_wrap) begin
            int_n_reg   <= 1'b0;
            int_cnt_reg <= INT_CW'(INT_CLKS - 1);
        end else if (!int_n_reg) begin
            if (int_cnt_reg == '0)
                int_n_reg <= 1'b1;
            else
                int_cnt_reg <= int_cnt_reg - INT_CW'(1);
        end
    end

    assign int_n = int_n_reg;
`else
    assign int_n = 1'b1;
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench: one instance at the reset defaults for line-level checks, one with a tiny raster for frame-level checks.
`timescale 1ns/1ps
module tb_video_timing_gen;

    logic       clk28 = 1'b0;
    logic       rst_n = 1'b0;
    logic       cfg_we = 1'b0;
    logic [2:0] cfg_addr = 3'd0;
    logic [8:0] cfg_wdata = 9'd0;

    int errors = 0;
    int checks = 0;

    logic [8:0] d_rdata, d_hc, d_vc;
    logic [2:0] d_ck;
    logic d_hsync_n, d_vsync_n, d_csync_n, d_blank, d_screen, d_ls, d_fs, d_even, d_blink, d_int_n;

    logic [8:0] s_rdata, s_hc, s_vc;
    logic [2:0] s_ck;
    logic s_hsync_n, s_vsync_n, s_csync_n, s_blank, s_screen, s_ls, s_fs, s_even, s_blink, s_int_n;

    always #5 clk28 = ~clk28;

    video_timing_gen u_def (
        .clk28(clk28), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .cfg_rdata(d_rdata), .ck(d_ck), .hc(d_hc), .vc(d_vc),
        .hsync_n(d_hsync_n), .vsync_n(d_vsync_n), .csync_n(d_csync_n), .blank(d_blank),
        .screen_show(d_screen), .line_start(d_ls), .frame_start(d_fs), .even_line(d_even),
        .blink(d_blink), .int_n(d_int_n)
    );

    // Tiny raster: 20 px x 12 lines = 80 clk/line, 960 clk/frame.
    video_timing_gen #(
        .DEF_H_TOTAL(20), .DEF_HBLANK_S(12), .DEF_HSYNC_S(14), .DEF_HSYNC_E(17),
        .DEF_HBLANK_E(19), .DEF_V_TOTAL(12), .DEF_VSYNC_S(8), .DEF_VSYNC_E(10)
    ) u_small (
        .clk28(clk28), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .cfg_rdata(s_rdata), .ck(s_ck), .hc(s_hc), .vc(s_vc),
        .hsync_n(s_hsync_n), .vsync_n(s_vsync_n), .csync_n(s_csync_n), .blank(s_blank),
        .screen_show(s_screen), .line_start(s_ls), .frame_start(s_fs), .even_line(s_even),
        .blink(s_blink), .int_n(s_int_n)
    );

    task automatic do_write(input logic [2:0] a, input logic [8:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        @(negedge clk28);
        cfg_we = 1'b0;
        $display("write addr=%0d data=%0d", a, d);
    endtask

    task automatic wait_fs(output int cyc);
        cyc = -1;
        for (int i = 1; i <= 3000; i++) begin
            @(negedge clk28);
            if (s_fs) begin cyc = i; break; end
        end
    endtask

    task automatic measure_frame(output int flen, output int first_ls, output int nls);
        flen = -1; first_ls = -1; nls = 0;
        for (int i = 1; i <= 3000; i++) begin
            @(negedge clk28);
            if (s_ls) begin
                nls++;
                if (first_ls < 0) first_ls = i;
            end
            if (s_fs) begin flen = i; break; end
        end
        $display("frame measured: len=%0d first_line=%0d lines=%0d", flen, first_ls, nls);
    endtask

    task automatic test_reset();
        logic [8:0] def_tab [8];
        def_tab = '{9'd448, 9'd322, 9'd334, 9'd367, 9'd407, 9'd320, 9'd248, 9'd256};
        repeat (3) @(negedge clk28);
        checks++; if (d_hc !== 9'd0 || d_vc !== 9'd0 || d_ck !== 3'd0) begin errors++;
            $display("FAIL reset_counters: got hc=%0d vc=%0d ck=%b, expected 0 0 000", d_hc, d_vc, d_ck); end
        checks++; if ({d_hsync_n, d_vsync_n, d_csync_n, d_int_n} !== 4'b1111) begin errors++;
            $display("FAIL reset_sync: got %b, expected 1111", {d_hsync_n, d_vsync_n, d_csync_n, d_int_n}); end
        checks++; if ({d_blank, d_screen, d_ls, d_fs, d_even, d_blink} !== 6'b0) begin errors++;
            $display("FAIL reset_flags: got %b, expected 000000", {d_blank, d_screen, d_ls, d_fs, d_even, d_blink}); end
        for (int i = 0; i < 8; i++) begin
            cfg_addr = 3'(i);
            #1;
            checks++; if (d_rdata !== def_tab[i]) begin errors++;
                $display("FAIL reset_cfg%0d: got %0d, expected %0d", i, d_rdata, def_tab[i]); end
            $display("reset cfg[%0d] = %0d", i, d_rdata);
        end
        cfg_addr = 3'd0;
        #1;
        checks++; if (s_rdata !== 9'd20) begin errors++;
            $display("FAIL reset_small_cfg: got %0d, expected 20", s_rdata); end
    endtask

    task automatic test_default_line();
        int hs_f = -1, hs_r = -1, bl_r = -1, bl_f = -1, sc_r = -1, sc_f = -1, ls = -1;
        logic phs = 1'b1, pbl = 1'b0, psc = 1'b0;
        for (int n = 1; n <= 1792; n++) begin
            @(negedge clk28);
            if (phs && !d_hsync_n && hs_f < 0) hs_f = n;
            if (!phs && d_hsync_n && hs_r < 0) hs_r = n;
            if (!pbl && d_blank && bl_r < 0) bl_r = n;
            if (pbl && !d_blank && bl_f < 0) bl_f = n;
            if (!psc && d_screen && sc_r < 0) sc_r = n;
            if (psc && !d_screen && sc_f < 0) sc_f = n;
            if (d_ls && ls < 0) ls = n;
            if (n == 1) begin checks++; if (d_ck !== 3'b001) begin errors++;
                $display("FAIL ck_hc0_1: got %b, expected 001", d_ck); end end
            if (n == 3) begin checks++; if (d_ck !== 3'b011) begin errors++;
                $display("FAIL ck_hc0_3: got %b, expected 011", d_ck); end end
            if (n == 7) begin checks++; if (d_ck !== 3'b111) begin errors++;
                $display("FAIL ck_hc0_7: got %b, expected 111", d_ck); end end
            if (n == 1791) begin checks++; if (d_hc !== 9'd447 || d_vc !== 9'd0) begin errors++;
                $display("FAIL line_end: got hc=%0d vc=%0d, expected 447 0", d_hc, d_vc); end end
            if (n == 1792) begin checks++; if (d_hc !== 9'd0 || d_vc !== 9'd1 || d_even !== 1'b1) begin errors++;
                $display("FAIL line_wrap: got hc=%0d vc=%0d even=%b, expected 0 1 1", d_hc, d_vc, d_even); end end
            phs = d_hsync_n; pbl = d_blank; psc = d_screen;
        end
        $display("default line: hs %0d..%0d blank %0d..%0d screen %0d..%0d line_start %0d",
                 hs_f, hs_r, bl_r, bl_f, sc_r, sc_f, ls);
        checks++; if (hs_f !== 1337 || hs_r !== 1469) begin errors++;
            $display("FAIL def_hsync: got %0d..%0d, expected 1337..1469", hs_f, hs_r); end
        checks++; if (bl_r !== 1289 || bl_f !== 1629) begin errors++;
            $display("FAIL def_hblank: got %0d..%0d, expected 1289..1629", bl_r, bl_f); end
        checks++; if (sc_r !== 52 || sc_f !== 1076) begin errors++;
            $display("FAIL def_screen: got %0d..%0d, expected 52..1076", sc_r, sc_f); end
        checks++; if (ls !== 1792) begin errors++;
            $display("FAIL def_line_len: got %0d, expected 1792", ls); end
    endtask

    task automatic test_frame_timing();
        int c, ls_first = -1, nls = 0, fs_at = -1, hs_f = -1, hs_r = -1, vs_f = -1, vs_r = -1;
        int bl_r = -1, int_r = -1, int_lo = 0;
        logic phs, pvs, pbl;
        wait_fs(c);
        checks++; if (c !== 128) begin errors++;
            $display("FAIL sync_small_fs: got %0d, expected 128", c); end
        checks++; if (s_hc !== 9'd0 || s_vc !== 9'd0) begin errors++;
            $display("FAIL fs_counters: got hc=%0d vc=%0d, expected 0 0", s_hc, s_vc); end
`ifdef VIDEO_TIMING_INT_EN
        checks++; if (s_int_n !== 1'b0) begin errors++;
            $display("FAIL int_at_fs: got %b, expected 0", s_int_n); end
`endif
        phs = s_hsync_n; pvs = s_vsync_n; pbl = s_blank;
        for (int m = 1; m <= 960; m++) begin
            @(negedge clk28);
            if (s_ls) begin nls++; if (ls_first < 0) ls_first = m; end
            if (s_fs && fs_at < 0) fs_at = m;
            if (phs && !s_hsync_n && hs_f < 0) hs_f = m;
            if (!phs && s_hsync_n && hs_r < 0) hs_r = m;
            if (pvs && !s_vsync_n && vs_f < 0) vs_f = m;
            if (!pvs && s_vsync_n && vs_r < 0) vs_r = m;
            if (!pbl && s_blank && bl_r < 0) bl_r = m;
            if (s_int_n && int_r < 0) int_r = m;
            if (!s_int_n) int_lo++;
            if (m == 57) begin checks++; if (s_csync_n !== 1'b0) begin errors++;
                $display("FAIL csync_hs_only: got %b, expected 0", s_csync_n); end end
            if (m == 650) begin checks++; if (s_csync_n !== 1'b0 || s_blank !== 1'b1) begin errors++;
                $display("FAIL vs_only: got csync=%b blank=%b, expected 0 1", s_csync_n, s_blank); end end
            if (m == 698) begin checks++; if (s_csync_n !== 1'b1) begin errors++;
                $display("FAIL csync_both: got %b, expected 1", s_csync_n); end end
            phs = s_hsync_n; pvs = s_vsync_n; pbl = s_blank;
        end
        $display("small frame: line %0d lines %0d fs %0d hs %0d..%0d vs %0d..%0d blank %0d",
                 ls_first, nls, fs_at, hs_f, hs_r, vs_f, vs_r, bl_r);
        checks++; if (ls_first !== 80 || nls !== 12 || fs_at !== 960) begin errors++;
            $display("FAIL small_raster: got line=%0d lines=%0d fs=%0d, expected 80 12 960", ls_first, nls, fs_at); end
        checks++; if (hs_f !== 57 || hs_r !== 69) begin errors++;
            $display("FAIL small_hsync: got %0d..%0d, expected 57..69", hs_f, hs_r); end
        checks++; if (vs_f !== 641 || vs_r !== 801) begin errors++;
            $display("FAIL small_vsync: got %0d..%0d, expected 641..801", vs_f, vs_r); end
        checks++; if (bl_r !== 49) begin errors++;
            $display("FAIL small_blank: got %0d, expected 49", bl_r); end
`ifdef VIDEO_TIMING_INT_EN
        checks++; if (int_r !== 128) begin errors++;
            $display("FAIL int_len: got rise at %0d, expected 128", int_r); end
`else
        checks++; if (int_lo !== 0) begin errors++;
            $display("FAIL int_idle: got %0d low cycles, expected 0", int_lo); end
`endif
    endtask

    task automatic test_double_buffer();
        int c, flen, fls, nls;
        repeat (200) @(negedge clk28);
        do_write(3'd0, 9'd24);
        do_write(3'd5, 9'd9);
        cfg_addr = 3'd0; #1;
        checks++; if (s_rdata !== 9'd24) begin errors++;
            $display("FAIL rdata_htotal: got %0d, expected 24", s_rdata); end
        wait_fs(c);
        checks++; if (c !== 758) begin errors++;
            $display("FAIL current_frame_kept: got %0d, expected 758", c); end
        measure_frame(flen, fls, nls);
        checks++; if (flen !== 864 || fls !== 96 || nls !== 9) begin errors++;
            $display("FAIL new_timing: got len=%0d line=%0d lines=%0d, expected 864 96 9", flen, fls, nls); end
    endtask

    task automatic test_shrink();
        int flen, fls, nls;
        repeat (75) @(negedge clk28);
        do_write(3'd0, 9'd10);
        measure_frame(flen, fls, nls);
        checks++; if (flen !== 788 || fls !== 20) begin errors++;
            $display("FAIL shrink_pending: got len=%0d line=%0d, expected 788 20", flen, fls); end
        measure_frame(flen, fls, nls);
        checks++; if (flen !== 360 || fls !== 40 || nls !== 9) begin errors++;
            $display("FAIL shrink_applied: got len=%0d line=%0d lines=%0d, expected 360 40 9", flen, fls, nls); end
    endtask

    task automatic test_write_at_wrap();
        int flen, fls, nls;
        repeat (359) @(negedge clk28);
        do_write(3'd0, 9'd16);
        checks++; if (s_fs !== 1'b1) begin errors++;
            $display("FAIL wrap_coincide: got frame_start=%b, expected 1", s_fs); end
        measure_frame(flen, fls, nls);
        checks++; if (flen !== 360 || fls !== 40) begin errors++;
            $display("FAIL wrap_write_absent: got len=%0d line=%0d, expected 360 40", flen, fls); end
        measure_frame(flen, fls, nls);
        checks++; if (flen !== 576 || fls !== 64) begin errors++;
            $display("FAIL wrap_write_present: got len=%0d line=%0d, expected 576 64", flen, fls); end
    endtask

    task automatic test_blink_even();
        int c, fcount = 0, tog = 0, tog1 = -1, tog2 = -1, bad_even = 0, bad_blink = 0;
        int nls = 0, hs_low = 0, int_hi = 0, int_lo = 0;
        logic pe, pb;
        do_write(3'd0, 9'd4);
        do_write(3'd5, 9'd4);
        do_write(3'd2, 9'd3);
        do_write(3'd3, 9'd1);
        wait_fs(c);
        checks++; if (c !== 572) begin errors++;
            $display("FAIL blink_sync: got %0d, expected 572", c); end
        pe = s_even; pb = s_blink;
        for (int i = 0; i < 2500 && fcount < 32; i++) begin
            @(negedge clk28);
            if ((s_even !== pe) !== s_ls) bad_even++;
            if (s_ls) nls++;
            if (!s_hsync_n) hs_low++;
            if (s_int_n) int_hi++; else int_lo++;
            if (s_blink !== pb) begin
                tog++;
                if (!s_fs) bad_blink++;
                if (tog1 < 0) tog1 = fcount + 1; else tog2 = fcount + 1;
            end
            if (s_fs) begin
                fcount++;
                $display("frame %0d: blink=%b even=%b", fcount, s_blink, s_even);
            end
            pe = s_even; pb = s_blink;
        end
        checks++; if (fcount !== 32 || nls !== 128) begin errors++;
            $display("FAIL blink_frames: got frames=%0d lines=%0d, expected 32 128", fcount, nls); end
        checks++; if (tog !== 2 || bad_blink !== 0 || (tog2 - tog1) !== 16) begin errors++;
            $display("FAIL blink_period: got toggles=%0d spacing=%0d off_fs=%0d, expected 2 16 0",
                     tog, tog2 - tog1, bad_blink); end
        checks++; if (bad_even !== 0) begin errors++;
            $display("FAIL even_line: got %0d bad cycles, expected 0", bad_even); end
        checks++; if (hs_low !== 0) begin errors++;
            $display("FAIL degenerate_hsync: got %0d low cycles, expected 0", hs_low); end
`ifdef VIDEO_TIMING_INT_EN
        checks++; if (int_hi !== 0) begin errors++;
            $display("FAIL int_restart: got %0d high cycles, expected 0", int_hi); end
`else
        checks++; if (int_lo !== 0) begin errors++;
            $display("FAIL int_idle_blink: got %0d low cycles, expected 0", int_lo); end
`endif
    endtask

    initial begin
        test_reset();
        @(negedge clk28);
        rst_n = 1'b1;
        test_default_line();
        test_frame_timing();
        test_double_buffer();
        test_shrink();
        test_write_at_wrap();
        test_blink_even();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
